// File: rtl/flags_context_register.sv
// Architectural flags register with masked ALU update, set/clear overrides
// and a small LIFO context stack for interrupt/CALL flag save and restore.
module flags_context_register #(
  parameter int unsigned NFLAGS = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ceFlags,
  input  logic [NFLAGS-1:0]                flags_alu,
  input  logic [NFLAGS-1:0]                wmask,
  input  logic [NFLAGS-1:0]                flag_set,
  input  logic [NFLAGS-1:0]                flag_clr,
  input  logic                             push,
  input  logic                             pop,
  input  logic                             err_clr,
  output logic [NFLAGS-1:0]                flags_out,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             empty,
  output logic                             full,
  output logic                             err
);

  // Count width covers 0..DEPTH; address width covers 0..DEPTH-1.
  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ENTRIES = 1 << AW;

  // Stack storage; entries at or above DEPTH are never addressed.
  logic [NFLAGS-1:0] stack_mem [ENTRIES];

  logic [NFLAGS-1:0] flags_q;
  logic [CW-1:0]     count_q;
  logic              empty_q;
  logic              full_q;
  logic              err_q;

  logic              push_only;
  logic              pop_only;
  logic              push_valid;
  logic              pop_valid;
  logic              err_event;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     top_idx;
  logic [NFLAGS-1:0] stage_a;
  logic [NFLAGS-1:0] flags_upd;
  logic [NFLAGS-1:0] flags_next;
  logic [CW-1:0]     count_next;
  logic              err_next;

  // Stack request decode: simultaneous push+pop is a misuse, never an operation.
  always_comb begin
    push_only  = push & ~pop;
    pop_only   = pop & ~push;
    push_valid = push_only & ~full_q;
    pop_valid  = pop_only & ~empty_q;
    err_event  = (push & pop) | (push_only & full_q) | (pop_only & empty_q);
    wr_idx     = AW'(count_q);
    top_idx    = AW'(count_q - CW'(1));
  end

  // Flag datapath: masked ALU merge, then set, then clear (clear wins).
  always_comb begin
    stage_a    = ceFlags ? ((flags_q & ~wmask) | (flags_alu & wmask)) : flags_q;
    flags_upd  = (stage_a | flag_set) & ~flag_clr;
    flags_next = flags_upd;
    if (pop_valid) begin
      flags_next = stack_mem[top_idx];
    end
  end

  // Occupancy and sticky error next-state; an error event beats err_clr.
  always_comb begin
    count_next = count_q;
    if (push_valid) begin
      count_next = count_q + CW'(1);
    end else if (pop_valid) begin
      count_next = count_q - CW'(1);
    end
    err_next = err_q;
    if (err_event) begin
      err_next = 1'b1;
    end else if (err_clr) begin
      err_next = 1'b0;
    end
  end

  // Architectural state; empty/full track the count that is being loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_next;
      count_q <= count_next;
      empty_q <= (count_next == CW'(0));
      full_q  <= (count_next == CW'(DEPTH));
      err_q   <= err_next;
    end
  end

  // Stack write of the pre-edge flags; contents are unreachable until written.
  always_ff @(posedge clk) begin
    if (!rst && push_valid) begin
      stack_mem[wr_idx] <= flags_q;
    end
  end

  assign flags_out = flags_q;
  assign count     = count_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign err       = err_q;

endmodule

// File: tb/tb_flags_context_register.sv
// Directed bench for flags_context_register at NFLAGS=5, DEPTH=4.
module tb_flags_context_register;

  localparam int unsigned NFLAGS = 5;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CW     = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              ceFlags;
  logic [NFLAGS-1:0] flags_alu;
  logic [NFLAGS-1:0] wmask;
  logic [NFLAGS-1:0] flag_set;
  logic [NFLAGS-1:0] flag_clr;
  logic              push;
  logic              pop;
  logic              err_clr;
  logic [NFLAGS-1:0] flags_out;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              err;

  int n_checks;
  int n_fail;

  flags_context_register #(.NFLAGS(NFLAGS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ceFlags   (ceFlags),
    .flags_alu (flags_alu),
    .wmask     (wmask),
    .flag_set  (flag_set),
    .flag_clr  (flag_clr),
    .push      (push),
    .pop       (pop),
    .err_clr   (err_clr),
    .flags_out (flags_out),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ceFlags   = 1'b0;
    flags_alu = '0;
    wmask     = '0;
    flag_set  = '0;
    flag_clr  = '0;
    push      = 1'b0;
    pop       = 1'b0;
    err_clr   = 1'b0;
  endtask

  // One clock: inputs applied at negedge take effect at the next posedge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic alu_load(input logic [NFLAGS-1:0] v);
    idle();
    ceFlags = 1'b1; flags_alu = v; wmask = '1;
    cyc();
  endtask

  logic [NFLAGS-1:0] pop_exp [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pop_exp[0] = 5'b00100; pop_exp[1] = 5'b00011;
    pop_exp[2] = 5'b00010; pop_exp[3] = 5'b00001;
    idle();
    rst = 1'b1;
    cyc(); cyc();
    check("rst_flags", 32'(flags_out), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_full",  32'(full), 32'h0);
    check("rst_err",   32'(err), 32'h0);
    rst = 1'b0;

    // Masked write, then hold with ceFlags low.
    idle(); ceFlags = 1'b1; flags_alu = 5'b11111; wmask = 5'b00011;
    cyc();
    check("mask_wr", 32'(flags_out), 32'h03);
    idle(); flags_alu = 5'b11100; wmask = 5'b11111;
    cyc();
    check("mask_hold", 32'(flags_out), 32'h03);

    // Set/clear priority.
    idle(); ceFlags = 1'b1; flags_alu = 5'b00000; wmask = 5'b11111;
    flag_set = 5'b00101; flag_clr = 5'b00100;
    cyc();
    check("set_clr", 32'(flags_out), 32'h01);

    // Save/restore with a concurrent flag change during the push.
    alu_load(5'b10101);
    check("sr_load", 32'(flags_out), 32'h15);
    idle(); push = 1'b1; ceFlags = 1'b1; flags_alu = 5'b01010; wmask = '1;
    cyc();
    check("sr_chg",   32'(flags_out), 32'h0A);
    check("sr_cnt1",  32'(count), 32'h1);
    check("sr_nempt", 32'(empty), 32'h0);
    idle(); pop = 1'b1; ceFlags = 1'b1; flags_alu = 5'b11111; wmask = '1;
    flag_set = 5'b11111;
    cyc();
    check("sr_rest",  32'(flags_out), 32'h15);
    check("sr_cnt0",  32'(count), 32'h0);
    check("sr_empty", 32'(empty), 32'h1);

    // Fill: each push saves i while the ALU loads i+1.
    alu_load(5'b00001);
    for (int i = 1; i <= 4; i++) begin
      idle(); push = 1'b1; ceFlags = 1'b1; flags_alu = NFLAGS'(i + 1); wmask = '1;
      cyc();
    end
    check("fill_cnt",  32'(count), 32'h4);
    check("fill_full", 32'(full), 32'h1);
    check("fill_err",  32'(err), 32'h0);
    idle(); push = 1'b1;
    cyc();
    check("ovf_err",   32'(err), 32'h1);
    check("ovf_cnt",   32'(count), 32'h4);
    check("ovf_flags", 32'(flags_out), 32'h05);
    for (int i = 0; i < 4; i++) begin
      idle(); pop = 1'b1;
      cyc();
      check($sformatf("pop%0d_flags", i), 32'(flags_out), 32'(pop_exp[i]));
      check($sformatf("pop%0d_cnt", i), 32'(count), 32'(3 - i));
    end
    check("drain_empty", 32'(empty), 32'h1);
    check("drain_full",  32'(full), 32'h0);
    check("err_sticky",  32'(err), 32'h1);
    idle(); err_clr = 1'b1;
    cyc();
    check("err_clr", 32'(err), 32'h0);

    // Underflow leaves flags alone; error beats err_clr in the same cycle.
    idle(); pop = 1'b1;
    cyc();
    check("udf_err",   32'(err), 32'h1);
    check("udf_flags", 32'(flags_out), 32'h01);
    check("udf_cnt",   32'(count), 32'h0);
    idle(); err_clr = 1'b1;
    cyc();
    check("udf_clr", 32'(err), 32'h0);
    idle(); pop = 1'b1; err_clr = 1'b1;
    cyc();
    check("err_vs_clr", 32'(err), 32'h1);
    idle(); err_clr = 1'b1;
    cyc();
    check("err_clr2", 32'(err), 32'h0);

    // Simultaneous push+pop at count=2 while flags still update.
    idle(); push = 1'b1; cyc(); cyc();
    check("pp_pre_cnt", 32'(count), 32'h2);
    idle(); push = 1'b1; pop = 1'b1; ceFlags = 1'b1; flags_alu = 5'b11111; wmask = 5'b00010;
    cyc();
    check("pp_cnt",   32'(count), 32'h2);
    check("pp_err",   32'(err), 32'h1);
    check("pp_flags", 32'(flags_out), 32'h03);

    // Async reset between edges with three contexts saved.
    idle(); push = 1'b1; ceFlags = 1'b1; flags_alu = 5'b11111; wmask = '1;
    cyc();
    check("ar_pre_cnt",   32'(count), 32'h3);
    check("ar_pre_flags", 32'(flags_out), 32'h1F);
    idle();
    #2 rst = 1'b1;
    #1;
    check("ar_flags", 32'(flags_out), 32'h0);
    check("ar_cnt",   32'(count), 32'h0);
    check("ar_empty", 32'(empty), 32'h1);
    check("ar_err",   32'(err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(); pop = 1'b1;
    cyc();
    check("ar_pop_err", 32'(err), 32'h1);
    check("ar_pop_cnt", 32'(count), 32'h0);
    check("ar_pop_flg", 32'(flags_out), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
